montmul_arbiter: RTL and testbench

//  - Shares one montgomery multiplier core between N_REQ requesters (exp engines, precompute unit).
//  - Round-robin grant; latches winner's operands; drives the core's start/operand/modulus inputs.
//  - Returns result plus one-cycle done to the granted requester only.
//  - Watchdog flags a core that never asserts done.

---
 rtl/montmul_arbiter_pkg.sv | 25 ++
 rtl/montmul_arbiter_if.sv | 31 +++
 rtl/montmul_arbiter_rr_pick.sv | 35 +++
 rtl/montmul_arbiter.sv | 141 ++++++++++++++
 tb/tb_montmul_arbiter.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/montmul_arbiter_pkg.sv
// Shared types and helpers for the montgomery multiplier arbiter.
package montmul_arbiter_pkg;

    localparam int unsigned DEF_N_REQ   = 2;
    localparam int unsigned DEF_WIDTH   = 512;
    localparam int unsigned DEF_TIMEOUT = 4096;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    // Bits needed to index n items; never less than one.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? 32'($clog2(n)) : 32'd1;
    endfunction

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 32'd0 : idx + 1;
    endfunction

endpackage

// File: rtl/montmul_arbiter_if.sv
// Requester and core-facing signal bundle for the montgomery multiplier arbiter.
interface montmul_arbiter_if #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned WIDTH = 512
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic [N_REQ*WIDTH-1:0] req_m;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       done;
    logic [WIDTH-1:0]       result;
    logic                   busy;
    logic                   err_timeout;
    logic                   mult_start;
    logic [WIDTH-1:0]       mult_a;
    logic [WIDTH-1:0]       mult_b;
    logic [WIDTH-1:0]       mult_m;
    logic [WIDTH-1:0]       mult_result;
    logic                   mult_done;

    modport slave (
        input  req, req_a, req_b, req_m, mult_result, mult_done,
        output gnt, done, result, busy, err_timeout, mult_start, mult_a, mult_b, mult_m
    );

    modport master (
        output req, req_a, req_b, req_m, mult_result, mult_done,
        input  gnt, done, result, busy, err_timeout, mult_start, mult_a, mult_b, mult_m
    );
endinterface

// File: rtl/montmul_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping.
module montmul_arbiter_rr_pick
    import montmul_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ
) (
    input  logic [N_REQ-1:0]           req_i,
    input  logic [idx_w(N_REQ)-1:0]    ptr_i,
    output logic [N_REQ-1:0]           win_oh_c_o,
    output logic [idx_w(N_REQ)-1:0]    win_idx_c_o,
    output logic                       valid_c_o
);
    localparam int unsigned IDXW = idx_w(N_REQ);

    int unsigned pos;

    always_comb begin
        win_oh_c_o  = '0;
        win_idx_c_o = '0;
        valid_c_o   = 1'b0;
        pos         = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            pos = 32'(ptr_i) + k;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            if (!valid_c_o && req_i[IDXW'(pos)]) begin
                valid_c_o               = 1'b1;
                win_idx_c_o             = IDXW'(pos);
                win_oh_c_o[IDXW'(pos)]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/montmul_arbiter.sv
// Shares one montgomery multiplier core between N_REQ requesters with
// round-robin grant, operand latching, result return and a core watchdog.
module montmul_arbiter
    import montmul_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ   = DEF_N_REQ,
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    montmul_arbiter_if.slave  bus
);
    localparam int unsigned IDXW = idx_w(N_REQ);
    localparam int unsigned WD_W = idx_w(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_e            state_q;
    logic [N_REQ-1:0]  gnt_q;
    logic [N_REQ-1:0]  done_q;
    logic [WIDTH-1:0]  result_q;
    logic              busy_q;
    logic              err_q;
    logic              start_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  m_q;
    logic [IDXW-1:0]   rr_ptr_q;
    logic [IDXW-1:0]   win_q;
    logic [WD_W-1:0]   wd_cnt_q;

    logic [N_REQ-1:0]  pick_oh_c;
    logic [IDXW-1:0]   pick_idx_c;
    logic              pick_valid_c;
    logic [WIDTH-1:0]  sel_a_c;
    logic [WIDTH-1:0]  sel_b_c;
    logic [WIDTH-1:0]  sel_m_c;

    montmul_arbiter_rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req_i       (bus.req),
        .ptr_i       (rr_ptr_q),
        .win_oh_c_o  (pick_oh_c),
        .win_idx_c_o (pick_idx_c),
        .valid_c_o   (pick_valid_c)
    );

    // Operand slice of the current winner.
    always_comb begin
        sel_a_c = '0;
        sel_b_c = '0;
        sel_m_c = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (IDXW'(i) == win_q) begin
                sel_a_c = bus.req_a[i*WIDTH +: WIDTH];
                sel_b_c = bus.req_b[i*WIDTH +: WIDTH];
                sel_m_c = bus.req_m[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            done_q   <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            start_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            rr_ptr_q <= '0;
            win_q    <= '0;
            wd_cnt_q <= '0;
        end else begin
            start_q <= 1'b0;
            done_q  <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid_c) begin
                        gnt_q   <= pick_oh_c;
                        win_q   <= pick_idx_c;
                        busy_q  <= 1'b1;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    a_q     <= sel_a_c;
                    b_q     <= sel_b_c;
                    m_q     <= sel_m_c;
                    start_q <= 1'b1;
                    state_q <= ST_START;
                end
                ST_START: begin
                    wd_cnt_q <= '0;
                    state_q  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.mult_done) begin
                        result_q <= bus.mult_result;
                        done_q   <= gnt_q;
                        state_q  <= ST_RESP;
                    end else if ((TIMEOUT != 0) && (wd_cnt_q == WD_LAST)) begin
                        // Core never answered: give up silently, requester sees no done.
                        err_q   <= 1'b1;
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + WD_W'(1);
                    end
                end
                ST_RESP: begin
                    rr_ptr_q <= IDXW'(rr_next(32'(win_q), N_REQ));
                    gnt_q    <= '0;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.done        = done_q;
    assign bus.result      = result_q;
    assign bus.busy        = busy_q;
    assign bus.err_timeout = err_q;
    assign bus.mult_start  = start_q;
    assign bus.mult_a      = a_q;
    assign bus.mult_b      = b_q;
    assign bus.mult_m      = m_q;

endmodule

// File: tb/tb_montmul_arbiter.sv
// Directed bench for montmul_arbiter with a fixed-latency stub multiplier core.
module tb_montmul_arbiter;

    localparam int unsigned N     = 2;
    localparam int unsigned W     = 16;
    localparam int unsigned TO    = 16;
    localparam int unsigned CORE_L = 10;

    typedef struct {
        logic [1:0]  req;
        logic [15:0] a0, b0, m0;
        logic [15:0] a1, b1, m1;
        logic [1:0]  gnt;
        logic [15:0] res;
    } vec_t;

    logic clk;
    logic reset;
    logic stub_en;
    logic spur;
    logic [7:0] stub_cnt;
    int checks;
    int failures;
    vec_t vecs[6];

    montmul_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

    montmul_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub core: done arrives CORE_L cycles after the first WAIT cycle.
    always @(posedge clk) begin
        if (reset) stub_cnt <= 8'd0;
        else if (bus.mult_start && stub_en) stub_cnt <= 8'(CORE_L + 1);
        else if (stub_cnt != 8'd0) stub_cnt <= stub_cnt - 8'd1;
    end
    assign bus.mult_done   = (stub_cnt == 8'd1) | spur;
    assign bus.mult_result = (bus.mult_m == 16'd0) ? 16'd0 :
                             16'((32'(bus.mult_a) * 32'(bus.mult_b)) % 32'(bus.mult_m));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int i);
        bus.req   = vecs[i].req;
        bus.req_a = {vecs[i].a1, vecs[i].a0};
        bus.req_b = {vecs[i].b1, vecs[i].b0};
        bus.req_m = {vecs[i].m1, vecs[i].m0};
    endtask

    // Starts just after a negedge (cycle 0); returns at the negedge of cycle 15.
    task automatic run_txn(input int i, input logic spur_in_start);
        logic stray;
        stray = 1'b0;
        drive(i);
        @(negedge clk);
        check("gnt_load", 32'(bus.gnt), 32'(vecs[i].gnt));
        check("busy_load", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check("start_pulse", 32'(bus.mult_start), 32'd1);
        spur = spur_in_start;
        for (int c = 3; c <= 13; c++) begin
            @(negedge clk);
            spur = 1'b0;
            if (bus.done != 2'b00 || bus.mult_start) stray = 1'b1;
        end
        check("no_early_done", 32'(stray), 32'd0);
        @(negedge clk);
        check("done", 32'(bus.done), 32'(vecs[i].gnt));
        check("result", 32'(bus.result), 32'(vecs[i].res));
        check("gnt_resp", 32'(bus.gnt), 32'(vecs[i].gnt));
        bus.req = 2'b00;
        @(negedge clk);
        check("gnt_clear", 32'(bus.gnt), 32'd0);
        check("done_clear", 32'(bus.done), 32'd0);
        check("busy_idle", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic [1:0] exp_g;
        logic [15:0] exp_r;
        logic found, multi;
        int pulses, pulse_cyc;

        checks = 0; failures = 0;
        stub_en = 1'b1; spur = 1'b0;
        bus.req = '0; bus.req_a = '0; bus.req_b = '0; bus.req_m = '0;

        vecs[0] = '{req:2'b01, a0:16'd3,  b0:16'd5,  m0:16'd7,  a1:16'd0,   b1:16'd0,   m1:16'd1,   gnt:2'b01, res:16'd1};
        vecs[1] = '{req:2'b11, a0:16'd4,  b0:16'd6,  m0:16'd11, a1:16'd9,   b1:16'd9,   m1:16'd13,  gnt:2'b10, res:16'd3};
        vecs[2] = '{req:2'b11, a0:16'd4,  b0:16'd6,  m0:16'd11, a1:16'd9,   b1:16'd9,   m1:16'd13,  gnt:2'b01, res:16'd2};
        vecs[3] = '{req:2'b01, a0:16'd7,  b0:16'd7,  m0:16'd10, a1:16'd9,   b1:16'd9,   m1:16'd13,  gnt:2'b01, res:16'd9};
        vecs[4] = '{req:2'b10, a0:16'd0,  b0:16'd0,  m0:16'd1,  a1:16'd100, b1:16'd200, m1:16'd997, gnt:2'b10, res:16'd60};
        vecs[5] = '{req:2'b10, a0:16'd0,  b0:16'd0,  m0:16'd1,  a1:16'd12,  b1:16'd12,  m1:16'd5,   gnt:2'b10, res:16'd4};

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_err", 32'(bus.err_timeout), 32'd0);
        check("rst_start", 32'(bus.mult_start), 32'd0);
        check("rst_mult_a", 32'(bus.mult_a), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_txn(i, 1'b0);

        // Both requesters held: grants must alternate, one at a time.
        drive(1);
        multi = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_r = (k % 2 == 0) ? 16'd2 : 16'd3;
            found = 1'b0;
            for (int c = 0; c < 30 && !found; c++) begin
                @(negedge clk);
                if ($countones(bus.gnt) > 1 || $countones(bus.done) > 1) multi = 1'b1;
                if (bus.done != 2'b00) found = 1'b1;
            end
            check("contend_seen", 32'(found), 32'd1);
            check("contend_done", 32'(bus.done), 32'(exp_g));
            check("contend_result", 32'(bus.result), 32'(exp_r));
        end
        check("contend_onehot", 32'(multi), 32'd0);
        bus.req = 2'b00;
        @(negedge clk);

        // Requester 1 drops its request right after being granted.
        drive(4);
        @(negedge clk);
        check("drop_gnt", 32'(bus.gnt), 32'd2);
        @(negedge clk);
        bus.req = 2'b00;
        pulses = 0; pulse_cyc = 0;
        for (int c = 3; c <= 30; c++) begin
            @(negedge clk);
            if (bus.done != 2'b00) begin
                pulses++;
                pulse_cyc = c;
                check("drop_done", 32'(bus.done), 32'd2);
            end
        end
        check("drop_pulses", 32'(pulses), 32'd1);
        check("drop_cycle", 32'(pulse_cyc), 32'd14);
        check("drop_result", 32'(bus.result), 32'd60);

        // Stray core done while idle and during START.
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        @(negedge clk);
        check("spur_idle_done", 32'(bus.done), 32'd0);
        check("spur_idle_result", 32'(bus.result), 32'd60);
        check("spur_idle_busy", 32'(bus.busy), 32'd0);
        run_txn(0, 1'b1);

        // Watchdog: the core never answers.
        stub_en = 1'b0;
        drive(0);
        @(negedge clk);
        check("wd_gnt", 32'(bus.gnt), 32'd1);
        found = 1'b0;
        for (int c = 2; c <= 18; c++) begin
            @(negedge clk);
            if (bus.done != 2'b00) found = 1'b1;
        end
        check("wd_err_before", 32'(bus.err_timeout), 32'd0);
        check("wd_busy_before", 32'(bus.busy), 32'd1);
        @(negedge clk);
        if (bus.done != 2'b00) found = 1'b1;
        check("wd_err", 32'(bus.err_timeout), 32'd1);
        check("wd_gnt_clear", 32'(bus.gnt), 32'd0);
        check("wd_busy", 32'(bus.busy), 32'd0);
        bus.req = 2'b00;
        @(negedge clk);
        check("wd_no_done", 32'(found), 32'd0);
        check("wd_sticky", 32'(bus.err_timeout), 32'd1);
        stub_en = 1'b1;

        // Reset in the middle of WAIT, then a fresh request.
        drive(0);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.req = 2'b00;
        check("mid_rst_gnt", 32'(bus.gnt), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_err", 32'(bus.err_timeout), 32'd0);
        check("mid_rst_result", 32'(bus.result), 32'd0);
        check("mid_rst_mult_a", 32'(bus.mult_a), 32'd0);
        check("mid_rst_mult_m", 32'(bus.mult_m), 32'd0);
        @(negedge clk);
        run_txn(0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
